// File: rtl/chip_bank_sched_if.sv
// ---------------------------------------------------------------------------
// chip_bank_sched_if
//
// Command channel between a memory controller front end and chip_bank_sched.
//   cmd_valid  master -> slave   command present
//   cmd_ready  slave  -> master  command consumed this cycle if cmd_valid is high
//   cmd_op     master -> slave   00=ACT, 01=RD, 10=WR, 11=PRE
//   cmd_bg     master -> slave   target bank group
//   cmd_ba     master -> slave   target bank within the group
//   cmd_row    master -> slave   row address (ACT only)
//   cmd_col    master -> slave   start column (RD/WR only)
//   cmd_err    slave  -> master  pulse: the consumed command was illegal and dropped
//
// The widths must match the parameters of the chip_bank_sched instance that
// uses this interface.
// ---------------------------------------------------------------------------
interface chip_bank_sched_if #(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int COLWIDTH = 10,
    parameter int CHWIDTH  = 5
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [BGWIDTH-1:0]  cmd_bg;
    logic [BAWIDTH-1:0]  cmd_ba;
    logic [CHWIDTH-1:0]  cmd_row;
    logic [COLWIDTH-1:0] cmd_col;
    logic                cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/chip_bank_sched.sv
// ---------------------------------------------------------------------------
// chip_bank_sched
//
// Command scheduler in front of one DRAM chip model with
// 2**BGWIDTH x 2**BAWIDTH banks. One ACT/RD/WR/PRE command is consumed per
// cycle over the cmd interface. Each bank runs its own
// IDLE/ACTIVATING/ACTIVE/PRECHARGING state machine with tRCD/tRAS/tRP
// timers; a single burst engine drives BL-beat read/write bursts onto the
// per-bank rd_o_wr/column outputs.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset (aborts bursts and timers)
//   cmd           chip_bank_sched_if.slave command channel
//   rd_o_wr       [bg][ba] 1=write, 0=read; only the burst target is non-zero
//   row           [bg][ba] row latched by the last accepted ACT
//   column        [bg][ba] column of the current beat; holds after the burst
//   burst_active  a burst beat is on the bus this cycle
//   burst_last    final beat of the current burst
//   bank_open     per-bank ACTIVE flag, index = bg*2**BAWIDTH + ba
//
// Optional build macro CHIP_BANK_SCHED_STATS_EN adds saturating 32-bit
// counters stat_act, stat_rd, stat_wr (accepted commands) and stat_err
// (cmd_err pulses), all cleared by rst.
// ---------------------------------------------------------------------------
module chip_bank_sched #(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int COLWIDTH = 10,
    parameter int CHWIDTH  = 5,
    parameter int BL       = 8,
    parameter int TRCD     = 4,
    parameter int TRAS     = 10,
    parameter int TRP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    chip_bank_sched_if.slave    cmd,
    output logic                rd_o_wr [2**BGWIDTH][2**BAWIDTH],
    output logic [CHWIDTH-1:0]  row     [2**BGWIDTH][2**BAWIDTH],
    output logic [COLWIDTH-1:0] column  [2**BGWIDTH][2**BAWIDTH],
    output logic                burst_active,
    output logic                burst_last,
    output logic [(2**BGWIDTH)*(2**BAWIDTH)-1:0] bank_open
`ifdef CHIP_BANK_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_act,
    output logic [31:0]         stat_rd,
    output logic [31:0]         stat_wr,
    output logic [31:0]         stat_err
`endif
);

    localparam int BANKSPERGROUP = 2**BAWIDTH;
    localparam int NB            = (2**BGWIDTH) * BANKSPERGROUP;
    localparam int BIDX          = BGWIDTH + BAWIDTH;
    localparam int LBL           = $clog2(BL);
    localparam int TMAX_RC       = (TRAS > TRCD) ? TRAS : TRCD;
    localparam int TMAX          = (TMAX_RC > TRP) ? TMAX_RC : TRP;
    localparam int TW            = $clog2(TMAX + 1);

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_PRE = 2'b11;

    localparam logic [TW-1:0]  T_ONE     = TW'(1);
    localparam logic [TW-1:0]  T_RCD     = TW'(TRCD - 1);
    localparam logic [TW-1:0]  T_RAS     = TW'(TRAS - 1);
    localparam logic [TW-1:0]  T_RP      = TW'(TRP - 1);
    localparam logic [LBL-1:0] B_ONE     = LBL'(1);
    localparam logic [LBL-1:0] B_LAST    = LBL'(BL - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ACTIVATING  = 2'd1,
        ST_ACTIVE      = 2'd2,
        ST_PRECHARGING = 2'd3
    } bank_state_t;

    // Per-bank state exported from the generate blocks for command decode.
    bank_state_t         state_arr [NB];
    logic [NB-1:0]       tras_zero;

    // Command decode.
    logic [BIDX-1:0]     sel;
    bank_state_t         sel_state;
    logic                sel_is_target;
    logic                engine_free;
    logic                cmd_legal;
    logic                cmd_stall;
    logic                cmd_accept;
    logic                go_act;
    logic                go_rw;
    logic                go_pre;

    // Burst engine.
    logic                burst_active_reg;
    logic [LBL-1:0]      beat_reg;
    logic [BIDX-1:0]     tgt_reg;
    logic                wr_reg    [NB];
    logic [COLWIDTH-1:0] col_reg   [NB];

    assign sel = {cmd.cmd_bg, cmd.cmd_ba};

    // -----------------------------------------------------------------------
    // Legality / stall decode for the presented command. A command is either
    // legal now, stalled (legal later once a timer or the burst engine frees
    // up), or permanently illegal; only the stall case holds cmd_ready low.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_state     = state_arr[sel];
        sel_is_target = burst_active_reg && (tgt_reg == sel);
        engine_free   = !burst_active_reg || burst_last;
        cmd_legal     = 1'b0;
        cmd_stall     = 1'b0;
        case (cmd.cmd_op)
            OP_ACT: begin
                if (sel_state == ST_IDLE) begin
                    cmd_legal = 1'b1;
                end else if (sel_state == ST_PRECHARGING) begin
                    cmd_stall = 1'b1;
                end
            end
            OP_RD, OP_WR: begin
                if (sel_state == ST_ACTIVE) begin
                    // A new burst may start on the last beat of the current one.
                    if (engine_free) begin
                        cmd_legal = 1'b1;
                    end else begin
                        cmd_stall = 1'b1;
                    end
                end else if (sel_state == ST_ACTIVATING) begin
                    cmd_stall = 1'b1;
                end
            end
            default: begin
                if (sel_state == ST_ACTIVE) begin
                    // The burst target stays open until its last beat is gone.
                    if (tras_zero[sel] && !sel_is_target) begin
                        cmd_legal = 1'b1;
                    end else begin
                        cmd_stall = 1'b1;
                    end
                end else if (sel_state == ST_ACTIVATING) begin
                    cmd_stall = 1'b1;
                end else begin
                    // PRE to a closed or closing bank is a harmless no-op.
                    cmd_legal = 1'b1;
                end
            end
        endcase
    end

    assign cmd.cmd_ready = !rst && !cmd_stall;
    assign cmd_accept    = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.cmd_err   = cmd_accept && !cmd_legal;
    assign go_act        = cmd_accept && cmd_legal && (cmd.cmd_op == OP_ACT);
    assign go_rw         = cmd_accept && cmd_legal &&
                           ((cmd.cmd_op == OP_RD) || (cmd.cmd_op == OP_WR));
    assign go_pre        = cmd_accept && cmd_legal && (cmd.cmd_op == OP_PRE) &&
                           (sel_state == ST_ACTIVE);

    // -----------------------------------------------------------------------
    // Per-bank state machines and timers.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            localparam int BGI = gi / BANKSPERGROUP;
            localparam int BAI = gi % BANKSPERGROUP;

            bank_state_t        state_reg;
            bank_state_t        state_next;
            logic [TW-1:0]      trcd_reg;
            logic [TW-1:0]      tras_reg;
            logic [TW-1:0]      trp_reg;
            logic [CHWIDTH-1:0] row_reg;
            logic               hit;

            assign hit = (sel == BIDX'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Transitions fire on the edge where the timer steps from 1 to 0,
            // so the new state is visible in the cycle the timer reads 0.
            // A timer loaded with 0 (parameter of 1) skips its waiting state.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (go_act && hit) begin
                            state_next = (TRCD <= 1) ? ST_ACTIVE : ST_ACTIVATING;
                        end
                    end
                    ST_ACTIVATING: begin
                        if (trcd_reg <= T_ONE) begin
                            state_next = ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (go_pre && hit) begin
                            state_next = (TRP <= 1) ? ST_IDLE : ST_PRECHARGING;
                        end
                    end
                    ST_PRECHARGING: begin
                        if (trp_reg <= T_ONE) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    trcd_reg <= '0;
                    tras_reg <= '0;
                    trp_reg  <= '0;
                    row_reg  <= '0;
                end else begin
                    if (go_act && hit) begin
                        trcd_reg <= T_RCD;
                        tras_reg <= T_RAS;
                        row_reg  <= cmd.cmd_row;
                    end else begin
                        trcd_reg <= (trcd_reg != '0) ? trcd_reg - T_ONE : '0;
                        tras_reg <= (tras_reg != '0) ? tras_reg - T_ONE : '0;
                    end
                    if (go_pre && hit) begin
                        trp_reg <= T_RP;
                    end else begin
                        trp_reg <= (trp_reg != '0) ? trp_reg - T_ONE : '0;
                    end
                end
            end

            assign state_arr[gi]     = state_reg;
            assign tras_zero[gi]     = (tras_reg == '0);
            assign bank_open[gi]     = (state_reg == ST_ACTIVE);
            assign row[BGI][BAI]     = row_reg;
            assign rd_o_wr[BGI][BAI] = wr_reg[gi];
            assign column[BGI][BAI]  = col_reg[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Burst engine. Beat 0 is registered on the accepting edge, so the first
    // beat appears the cycle after RD/WR is consumed. Columns step through
    // the BL-aligned block, wrapping in the low log2(BL) bits.
    // -----------------------------------------------------------------------
    assign burst_active = burst_active_reg;
    assign burst_last   = burst_active_reg && (beat_reg == B_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_active_reg <= 1'b0;
            beat_reg         <= '0;
            tgt_reg          <= '0;
            for (int i = 0; i < NB; i++) begin
                wr_reg[i]  <= 1'b0;
                col_reg[i] <= '0;
            end
        end else if (go_rw) begin
            burst_active_reg <= 1'b1;
            beat_reg         <= '0;
            tgt_reg          <= sel;
            for (int i = 0; i < NB; i++) begin
                wr_reg[i] <= 1'b0;
            end
            wr_reg[sel]  <= (cmd.cmd_op == OP_WR);
            col_reg[sel] <= cmd.cmd_col;
        end else if (burst_active_reg) begin
            if (burst_last) begin
                burst_active_reg <= 1'b0;
                wr_reg[tgt_reg]  <= 1'b0;
            end else begin
                beat_reg         <= beat_reg + B_ONE;
                col_reg[tgt_reg] <= {col_reg[tgt_reg][COLWIDTH-1:LBL],
                                     col_reg[tgt_reg][LBL-1:0] + B_ONE};
            end
        end
    end

`ifdef CHIP_BANK_SCHED_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating command statistics.
    // -----------------------------------------------------------------------
    logic go_rd;
    logic go_wr;

    assign go_rd = go_rw && (cmd.cmd_op == OP_RD);
    assign go_wr = go_rw && (cmd.cmd_op == OP_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_act <= '0;
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else begin
            if (go_act && (stat_act != '1)) stat_act <= stat_act + 32'd1;
            if (go_rd && (stat_rd != '1)) stat_rd <= stat_rd + 32'd1;
            if (go_wr && (stat_wr != '1)) stat_wr <= stat_wr + 32'd1;
            if (cmd.cmd_err && (stat_err != '1)) stat_err <= stat_err + 32'd1;
        end
    end
`endif

endmodule

// File: doc/chip_bank_sched.md
Name: chip_bank_sched

Overview:
- Command scheduler in front of one DRAM chip model (BANKGROUPS x BANKSPERGROUP banks).
- Accepts one ACT/RD/WR/PRE command per cycle over a valid/ready interface.
- Tracks per-bank open/closed state and tRCD/tRAS/tRP timers.
- Sequences BL-beat bursts by driving each bank's rd_o_wr, row and column inputs.

Parameters:
- BGWIDTH, 2, bank-group address bits; BANKGROUPS = 2**BGWIDTH
- BAWIDTH, 2, bank-in-group address bits; BANKSPERGROUP = 2**BAWIDTH
- COLWIDTH, 10, column address bits
- CHWIDTH, 5, row address bits
- BL, 8, burst length in beats; power of 2, must be >= 2
- TRCD, 4, minimum cycles from ACT accept to RD/WR accept, same bank
- TRAS, 10, minimum cycles from ACT accept to PRE accept, same bank
- TRP, 4, cycles from PRE accept until the bank is IDLE

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when cmd_valid is also high
- cmd_op  input  2  00=ACT, 01=RD, 10=WR, 11=PRE
- cmd_bg  input  BGWIDTH  target bank group
- cmd_ba  input  BAWIDTH  target bank
- cmd_row  input  CHWIDTH  row, used by ACT only
- cmd_col  input  COLWIDTH  start column, used by RD/WR only
- cmd_err  output  1  one-cycle pulse: illegal command consumed and dropped
- rd_o_wr  output  1 per bank, [BANKGROUPS][BANKSPERGROUP]  1=write, 0=read
- row  output  CHWIDTH per bank, same array  open row
- column  output  COLWIDTH per bank, same array  current beat column
- burst_active  output  1  a burst beat is on the bus this cycle
- burst_last  output  1  final beat of the current burst
- bank_open  output  BANKGROUPS*BANKSPERGROUP  bank in ACTIVE state; index = bg*BANKSPERGROUP+ba

Behaviour:
- Reset (rst=1 at a clock edge): all banks IDLE; all timers 0; burst engine idle. All outputs 0 (rd_o_wr, row, column, burst_active, burst_last, bank_open, cmd_err). cmd_ready is also 0 while rst=1.
- Reset mid-burst or mid-timer aborts everything immediately; there is no drain.
- Per-bank FSM:
  - IDLE -ACT-> ACTIVATING; loads tRCD timer with TRCD-1 and tRAS timer with TRAS-1.
  - ACTIVATING -> ACTIVE when the tRCD timer reaches 0.
  - ACTIVE -PRE-> PRECHARGING; loads tRP timer with TRP-1.
  - PRECHARGING -> IDLE when the tRP timer reaches 0.
  - Timers decrement every cycle and saturate at 0.
- cmd_ready is combinational from the current state. It is 1 when the presented command is legal now, or permanently illegal. It is 0 (stall) when the command is legal but waiting on a timer or the burst engine.
- ACT:
  - IDLE bank: accepted; that bank's row output registers cmd_row on the next edge.
  - PRECHARGING bank: stalls.
  - ACTIVATING/ACTIVE bank: illegal, so cmd_err pulses.
- RD/WR:
  - ACTIVE bank: accepted if the burst engine is idle or in its last beat.
  - ACTIVATING bank: stalls.
  - IDLE/PRECHARGING bank: illegal, cmd_err pulses.
- PRE:
  - ACTIVE bank: accepted when the tRAS timer is 0 and the bank is not the current burst target. If the bank is the burst target, PRE stalls until burst_last has been seen.
  - ACTIVATING bank: stalls.
  - IDLE bank: no-op, accepted, no error.
  - PRECHARGING bank: no-op, accepted, no error.
- Result: ACT accepted at cycle T gives earliest RD/WR at T+TRCD and earliest PRE at T+TRAS. PRE accepted at T gives earliest ACT at T+TRP.
- Burst:
  - RD/WR accepted at cycle T drives beats k=0..BL-1 on cycles T+1..T+BL.
  - burst_active=1 on each beat; burst_last=1 on beat BL-1.
  - Target bank's rd_o_wr = op-is-WR for the whole burst.
  - column = cmd_col with its low log2(BL) bits replaced by (cmd_col low bits + k) mod BL (wrap within the BL-aligned block).
  - Back-to-back: RD/WR accepted on the last-beat cycle starts its beat 0 the next cycle, with no gap.
- Non-target banks: rd_o_wr is 0; column holds its last value; row holds the open row.
- ACT/PRE to other banks may be accepted during a burst. Only one command is accepted per cycle.
- bank_open bit = 1 in ACTIVE state only.

Optional Feature:
- Macro: CHIP_BANK_SCHED_STATS_EN.
- Defined: adds outputs stat_act, stat_rd, stat_wr, stat_err, each 32 bits. Each counts accepted commands of its type (err counts cmd_err pulses), saturates at 2^32-1, and clears on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ACT bg1/ba2 row 5 at T, then RD col 0x013 → cmd_ready low until T+4. Beats T+5..T+12 give columns 0x013,0x014,0x015,0x016,0x017,0x010,0x011,0x012; rd_o_wr=0; burst_last at T+12.
- WR then RD to the same open bank, the RD presented during the last beat → 16 consecutive burst_active cycles. rd_o_wr=1 for the first 8, 0 for the next 8.
- ACT at T then PRE, same bank → PRE accepted at T+10. ACT presented at T+11 stalls until T+14. bank_open falls at T+11.
- RD to an IDLE bank, and ACT to an ACTIVE bank → cmd_ready=1 and a one-cycle cmd_err for each; no state change; no burst.
- PRE to the burst target bank mid-burst → stalls until the burst_last cycle has passed. A concurrent ACT to a different IDLE bank is accepted.
- rst asserted on beat 3 of a write burst → next cycle all outputs 0, all banks IDLE, and ACT accepted immediately after rst drops.
